// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request, acknowledge and memory-side signals of the data-memory arbiter.
//   loader   : ld_req, ld_addr, ld_wdata -> ld_ack
//   pipeline : cpu_req, cpu_we, cpu_addr, cpu_wdata -> cpu_rdata, cpu_done
//   memory   : mem_sig, mem_rw, mem_addr, mem_wdata -> mem_rdata, mem_finish
//   modport slave  : arbiter view
//   modport master : requester/memory view
interface dmem_arbiter_if;
   logic        ld_req;
   logic [26:0] ld_addr;
   logic [31:0] ld_wdata;
   logic        ld_ack;
   logic        cpu_req;
   logic        cpu_we;
   logic [26:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_done;
   logic        mem_sig;
   logic        mem_rw;
   logic [26:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_finish;
   modport slave (
      input  ld_req, ld_addr, ld_wdata, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_finish,
      output ld_ack, cpu_rdata, cpu_done, mem_sig, mem_rw, mem_addr, mem_wdata
   );
   modport master (
      output ld_req, ld_addr, ld_wdata, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_finish,
      input  ld_ack, cpu_rdata, cpu_done, mem_sig, mem_rw, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter between the program loader and the pipeline for one data-memory port.
//   clk, rstn   : core clock, asynchronous active-low reset
//   bus         : dmem_arbiter_if.slave (loader, pipeline and memory handshakes)
//   busy        : high whenever an access is in flight or being acknowledged
//   timeout_err : sticky memory-timeout flag
//   DMEM_ARB_TIMEOUT_EN : when defined, BUSY gives up after TIMEOUT_CYCLES cycles and answers
//                         with 32'hDEADBEEF; when undefined BUSY waits forever and timeout_err is 0
module dmem_arbiter
`ifdef DMEM_ARB_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
)
`endif
(
   input  logic          clk,
   input  logic          rstn,
   dmem_arbiter_if.slave bus,
   output logic          busy,
   output logic          timeout_err
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t state, state_nx;
   logic owner, last_grant, pending, grant_cpu, tmo;
   assign pending = bus.ld_req | bus.cpu_req;
   // last_grant=1 means the pipeline was served last, so the loader wins a tie
   assign grant_cpu = bus.cpu_req & (~bus.ld_req | ~last_grant);
`ifdef DMEM_ARB_TIMEOUT_EN
   logic [31:0] cnt;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) cnt <= '0;
      else cnt <= (state == BUSY) ? cnt + 32'd1 : '0;
   // fires in the TIMEOUT_CYCLES-th BUSY cycle; a real finish in that cycle takes priority
   assign tmo = (state == BUSY) && !bus.mem_finish && (cnt + 32'd1 == TIMEOUT_CYCLES);
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) timeout_err <= 1'b0;
      else if (tmo) timeout_err <= 1'b1;
`else
   assign tmo = 1'b0;
   assign timeout_err = 1'b0;
`endif
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      busy = 1'b0;
      bus.mem_sig = 1'b0;
      bus.ld_ack = 1'b0;
      bus.cpu_done = 1'b0;
      state_nx = (state == IDLE) ? (pending ? BUSY : IDLE) :
                 (state == BUSY) ? ((bus.mem_finish | tmo) ? RESP : BUSY) : IDLE;
      busy = state != IDLE;
      bus.mem_sig = state == BUSY;
      bus.ld_ack = (state == RESP) && !owner;
      bus.cpu_done = (state == RESP) && owner;
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         owner <= 1'b0;
         last_grant <= 1'b1;
         bus.mem_rw <= 1'b1;
         bus.mem_addr <= '0;
         bus.mem_wdata <= '0;
         bus.cpu_rdata <= '0;
      end else begin
         if (state == IDLE && pending) begin
            owner <= grant_cpu;
            bus.mem_rw <= grant_cpu & ~bus.cpu_we;
            bus.mem_addr <= grant_cpu ? bus.cpu_addr : bus.ld_addr;
            bus.mem_wdata <= grant_cpu ? bus.cpu_wdata : bus.ld_wdata;
         end
         if (state == BUSY && bus.mem_finish && owner && bus.mem_rw) bus.cpu_rdata <= bus.mem_rdata;
         if (tmo) bus.cpu_rdata <= 32'hDEADBEEF;
         if (state == RESP) last_grant <= owner;
      end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed, table-driven bench for dmem_arbiter plus hand-written reset/tie/timeout sequences.
module tb_dmem_arbiter;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic busy, timeout_err;
   int n_chk = 0;
   int n_fail = 0;
   dmem_arbiter_if bus();
`ifdef DMEM_ARB_TIMEOUT_EN
   dmem_arbiter #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .rstn(rstn), .bus(bus), .busy(busy), .timeout_err(timeout_err));
`else
   dmem_arbiter dut (.clk(clk), .rstn(rstn), .bus(bus), .busy(busy), .timeout_err(timeout_err));
`endif
   always #5 clk = ~clk;
   typedef struct {
      logic        ld_req, cpu_req, cpu_we;
      logic [26:0] ld_addr, cpu_addr;
      logic [31:0] ld_wdata, cpu_wdata, rdata;
      int          d;
      logic        exp_cpu, exp_rw;
      logic [26:0] exp_addr;
      logic [31:0] exp_wdata, exp_rdata;
   } vec_t;
   vec_t vecs [9];
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   always @(negedge clk)
      if (rstn && ((bus.ld_ack && bus.cpu_done) || (bus.mem_sig && !busy))) begin
         n_fail++;
         $display("FAIL exclusivity: ld_ack=%b cpu_done=%b mem_sig=%b busy=%b", bus.ld_ack, bus.cpu_done, bus.mem_sig, busy);
      end
   task automatic run_vec(input int i, input vec_t v);
      bus.ld_req = v.ld_req;
      bus.cpu_req = v.cpu_req;
      bus.cpu_we = v.cpu_we;
      bus.ld_addr = v.ld_addr;
      bus.cpu_addr = v.cpu_addr;
      bus.ld_wdata = v.ld_wdata;
      bus.cpu_wdata = v.cpu_wdata;
      tick();
      chk($sformatf("v%0d mem_sig", i), {31'd0, bus.mem_sig}, 32'd1);
      chk($sformatf("v%0d mem_rw", i), {31'd0, bus.mem_rw}, {31'd0, v.exp_rw});
      chk($sformatf("v%0d mem_addr", i), {5'd0, bus.mem_addr}, {5'd0, v.exp_addr});
      chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, v.exp_wdata);
      repeat (v.d) tick();
      chk($sformatf("v%0d held", i), {4'd0, bus.mem_sig, bus.mem_addr}, {4'd1, v.exp_addr});
      bus.mem_rdata = v.rdata;
      bus.mem_finish = 1'b1;
      tick();
      bus.mem_finish = 1'b0;
      bus.ld_req = 1'b0;
      bus.cpu_req = 1'b0;
      chk($sformatf("v%0d ack", i), {29'd0, bus.mem_sig, bus.ld_ack, bus.cpu_done}, {29'd0, 1'b0, ~v.exp_cpu, v.exp_cpu});
      chk($sformatf("v%0d cpu_rdata", i), bus.cpu_rdata, v.exp_rdata);
      tick();
      chk($sformatf("v%0d idle", i), {29'd0, busy, bus.ld_ack, bus.cpu_done}, 32'd0);
   endtask
   initial begin
      vec_t v;
      logic seen;
      int n;
      vecs[0] = '{1'b1, 1'b0, 1'b0, 27'h100, 27'h0, 32'hAABBCCDD, 32'h0, 32'h0, 4, 1'b0, 1'b0, 27'h100, 32'hAABBCCDD, 32'h0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 27'h0, 27'h40, 32'h0, 32'h0BADF00D, 32'h12345678, 0, 1'b1, 1'b1, 27'h40, 32'h0BADF00D, 32'h12345678};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 27'h0, 27'h7FFFFFF, 32'h0, 32'hFFFFFFFF, 32'h11111111, 2, 1'b1, 1'b0, 27'h7FFFFFF, 32'hFFFFFFFF, 32'h12345678};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 27'h1, 27'h2, 32'h01020304, 32'h0, 32'h99, 1, 1'b0, 1'b0, 27'h1, 32'h01020304, 32'h12345678};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 27'h5, 27'h3, 32'h05050505, 32'h0, 32'hCAFEF00D, 0, 1'b1, 1'b1, 27'h3, 32'h0, 32'hCAFEF00D};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 27'h6, 27'h7, 32'h06060606, 32'h07070707, 32'h0, 3, 1'b0, 1'b0, 27'h6, 32'h06060606, 32'hCAFEF00D};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 27'h0, 27'h8, 32'h0, 32'h0, 32'h88888888, 0, 1'b1, 1'b1, 27'h8, 32'h0, 32'h88888888};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 27'h9, 27'h0, 32'h09090909, 32'h0, 32'h0, 0, 1'b0, 1'b0, 27'h9, 32'h09090909, 32'h88888888};
      vecs[8] = '{1'b1, 1'b0, 1'b0, 27'h7FFFFFF, 27'h0, 32'h0, 32'h0, 32'h0, 1, 1'b0, 1'b0, 27'h7FFFFFF, 32'h0, 32'h88888888};
      bus.ld_req = 0; bus.cpu_req = 0; bus.cpu_we = 0; bus.ld_addr = 0; bus.cpu_addr = 0;
      bus.ld_wdata = 0; bus.cpu_wdata = 0; bus.mem_rdata = 0; bus.mem_finish = 0;
      tick();
      tick();
      chk("reset ctrl", {26'd0, busy, timeout_err, bus.mem_sig, bus.ld_ack, bus.cpu_done, bus.mem_rw}, 32'd1);
      chk("reset addr", {5'd0, bus.mem_addr}, 32'd0);
      chk("reset data", bus.mem_wdata | bus.cpu_rdata, 32'd0);
      rstn = 1'b1;
      tick();
      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);
      // spurious finish while idle
      bus.mem_finish = 1'b1;
      bus.mem_rdata = 32'h5A5A5A5A;
      tick();
      tick();
      chk("spurious", {28'd0, busy, bus.mem_sig, bus.ld_ack, bus.cpu_done}, 32'd0);
      chk("spurious rdata", bus.cpu_rdata, 32'h88888888);
      bus.mem_finish = 1'b0;
      tick();
      // reset in the middle of a pipeline access after a loader grant
      bus.cpu_req = 1'b1;
      bus.cpu_we = 1'b0;
      bus.cpu_addr = 27'h55;
      tick();
      chk("rstbusy pre", {31'd0, bus.mem_sig}, 32'd1);
      rstn = 1'b0;
      #1;
      chk("rstbusy async", {29'd0, bus.mem_sig, busy, bus.mem_rw}, 32'd1);
      bus.cpu_req = 1'b0;
      tick();
      rstn = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         tick();
         seen |= bus.ld_ack | bus.cpu_done | busy;
      end
      chk("rstbusy no done", {31'd0, seen}, 32'd0);
      v = '{1'b1, 1'b1, 1'b0, 27'h11, 27'h22, 32'h11111111, 32'h22222222, 32'h0, 0, 1'b0, 1'b0, 27'h11, 32'h11111111, 32'h0};
      run_vec(9, v);
      // both requests held from reset: grants alternate L,C,L,C,L,C
      rstn = 1'b0;
      bus.ld_req = 1'b1;
      bus.cpu_req = 1'b1;
      bus.cpu_we = 1'b0;
      tick();
      rstn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         n = 0;
         while (!bus.mem_sig && n < 10) begin
            tick();
            n++;
         end
         bus.mem_finish = 1'b1;
         tick();
         bus.mem_finish = 1'b0;
         if (i == 5) begin
            bus.ld_req = 1'b0;
            bus.cpu_req = 1'b0;
         end
         chk($sformatf("rr grant %0d", i), {30'd0, bus.ld_ack, bus.cpu_done}, (i % 2 == 0) ? 32'd2 : 32'd1);
         tick();
      end
      tick();
      chk("rr idle", {31'd0, busy}, 32'd0);
`ifdef DMEM_ARB_TIMEOUT_EN
      bus.cpu_req = 1'b1;
      bus.cpu_we = 1'b0;
      bus.cpu_addr = 27'h77;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 30) begin
         tick();
         seen = bus.cpu_done;
         n++;
      end
      bus.cpu_req = 1'b0;
      chk("timeout done", {31'd0, seen}, 32'd1);
      chk("timeout cycles", n, 32'd9);
      chk("timeout rdata", bus.cpu_rdata, 32'hDEADBEEF);
      tick();
      chk("timeout err sticky", {31'd0, timeout_err}, 32'd1);
`else
      chk("timeout_err tied", {31'd0, timeout_err}, 32'd0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
